// File: rtl/mult_ctrl.sv
// Sequencing FSM for the shift-add multiplier: drives datapath selects from a start/done/ack handshake.
// Optional early exit on Reg_B == 0 is enabled by defining MULT_CTRL_EARLY_EXIT_EN.
module mult_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             iStart,
  input  logic             iAck,
  input  logic             B_LSB,
  input  logic             iB_Zero,
  output logic             oReady,
  output logic             oDone,
  output logic             b_sel,
  output logic             a_sel,
  output logic             prod_sel,
  output logic             add_sel,
  output logic             Shift_Enable,
  output logic [CNT_W-1:0] oIter
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t           state_r;
  state_t           next_state_s;
  logic [CNT_W-1:0] counter_r;
  logic [CNT_W-1:0] next_count_s;

`ifndef MULT_CTRL_EARLY_EXIT_EN
  logic unused_b_zero_s;
  assign unused_b_zero_s = iB_Zero;
`endif

  // State and iteration counter registers with synchronous reset
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r   <= IDLE;
      counter_r <= {CNT_W{1'b0}};
    end else begin
      state_r   <= next_state_s;
      counter_r <= next_count_s;
    end
  end

  // Next-state and next-counter decode
  always_comb begin
    next_state_s = state_r;
    next_count_s = counter_r;
    case (state_r)
      IDLE: begin
        if (iStart) begin
          next_state_s = CALC;
          next_count_s = {CNT_W{1'b0}};
        end else begin
          next_state_s = IDLE;
          next_count_s = {CNT_W{1'b0}};
        end
      end
      CALC: begin
`ifdef MULT_CTRL_EARLY_EXIT_EN
        // Remaining multiplier bits are all zero, so further iterations add nothing
        if (iB_Zero) begin
          next_state_s = DONE;
          next_count_s = {CNT_W{1'b0}};
        end else
`endif
        if (counter_r == LAST_ITER) begin
          next_state_s = DONE;
          next_count_s = {CNT_W{1'b0}};
        end else begin
          next_state_s = CALC;
          next_count_s = counter_r + CNT_W'(1);
        end
      end
      DONE: begin
        if (iAck) begin
          next_state_s = IDLE;
          next_count_s = {CNT_W{1'b0}};
        end else begin
          next_state_s = DONE;
          next_count_s = counter_r;
        end
      end
      default: begin
        next_state_s = IDLE;
        next_count_s = {CNT_W{1'b0}};
      end
    endcase
  end

  // Datapath select and handshake decode; add_sel is Mealy in CALC
  always_comb begin
    oReady       = 1'b0;
    oDone        = 1'b0;
    a_sel        = 1'b0;
    b_sel        = 1'b0;
    prod_sel     = 1'b0;
    add_sel      = 1'b0;
    Shift_Enable = 1'b0;
    case (state_r)
      IDLE: begin
        oReady = 1'b1;
      end
      CALC: begin
        a_sel        = 1'b1;
        b_sel        = 1'b1;
        prod_sel     = 1'b1;
        Shift_Enable = 1'b1;
`ifdef MULT_CTRL_EARLY_EXIT_EN
        add_sel      = B_LSB & ~iB_Zero;
`else
        add_sel      = B_LSB;
`endif
      end
      DONE: begin
        oDone    = 1'b1;
        a_sel    = 1'b1;
        b_sel    = 1'b1;
        prod_sel = 1'b1;
      end
      default: begin
        oReady = 1'b0;
      end
    endcase
  end

  assign oIter = counter_r;

endmodule

// File: tb/tb_mult_ctrl.sv
// Self-checking bench for mult_ctrl: a behavioural shift-add datapath closes the loop and
// results are compared against plain A*B and latency rules computed from B's bit pattern.
module tb_mult_ctrl;
  localparam int WIDTH = 32;
  localparam int CNT_W = $clog2(WIDTH);

  logic             Clock = 1'b0;
  logic             Reset = 1'b0;
  logic             iStart = 1'b0;
  logic             iAck = 1'b0;
  logic             B_LSB;
  logic             iB_Zero;
  logic             oReady, oDone, b_sel, a_sel, prod_sel, add_sel, Shift_Enable;
  logic [CNT_W-1:0] oIter;

  logic [31:0] Data_A = 32'd0;
  logic [31:0] Data_B = 32'd0;
  logic [31:0] reg_a = 32'd0;
  logic [31:0] reg_b = 32'd0;
  logic [31:0] reg_prod = 32'd0;
  logic [31:0] prod;

  int checks = 0;
  int errors = 0;

  mult_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .Clock(Clock), .Reset(Reset), .iStart(iStart), .iAck(iAck),
    .B_LSB(B_LSB), .iB_Zero(iB_Zero), .oReady(oReady), .oDone(oDone),
    .b_sel(b_sel), .a_sel(a_sel), .prod_sel(prod_sel), .add_sel(add_sel),
    .Shift_Enable(Shift_Enable), .oIter(oIter)
  );

  always #5 Clock = ~Clock;

  // Behavioural datapath driven by the controller's selects
  always @(posedge Clock) begin
    reg_a    <= !a_sel ? Data_A : (Shift_Enable ? reg_a << 1 : reg_a);
    reg_b    <= !b_sel ? Data_B : (Shift_Enable ? reg_b >> 1 : reg_b);
    reg_prod <= !prod_sel ? 32'd0 : (add_sel ? reg_prod + reg_a : reg_prod);
  end
  assign B_LSB   = reg_b[0];
  assign iB_Zero = (reg_b == 32'd0);
  assign prod    = oDone ? reg_prod : 32'd0;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  function automatic int exp_latency(input logic [15:0] b);
`ifdef MULT_CTRL_EARLY_EXIT_EN
    int msb;
    if (b == 16'd0) return 1;
    msb = 0;
    for (int i = 0; i < 16; i++) if (b[i]) msb = i;
    return msb + 2;
`else
    return WIDTH;
`endif
  endfunction

  // Start a multiplication, wait for oDone; return latency and per-iteration add_sel mask
  task automatic run_mult(input logic [15:0] a, input logic [15:0] b, input int pulse_at,
                          output int lat, output logic [31:0] mask);
    Data_A = {16'd0, a};
    Data_B = {16'd0, b};
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    lat = 0;
    mask = 32'd0;
    while (!oDone && lat < 100) begin
      if (Shift_Enable) mask[oIter] = add_sel;
      iStart = (lat == pulse_at);
      tick();
      iStart = 1'b0;
      lat++;
    end
    if (lat >= 100) begin
      errors++;
      $display("FAIL timeout: oDone not seen after %0d cycles (A=%0d B=%0d)", lat, a, b);
    end
  endtask

  task automatic check_mult(input string name, input logic [15:0] a, input logic [15:0] b,
                            input int pulse_at);
    int lat;
    logic [31:0] mask;
    logic [31:0] expp;
    run_mult(a, b, pulse_at, lat, mask);
    expp = 32'(a) * 32'(b);
    checks++;
    if (prod !== expp) begin
      errors++;
      $display("FAIL %s prod: got %h expected %h", name, prod, expp);
    end
    checks++;
    if (lat !== exp_latency(b)) begin
      errors++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_latency(b));
    end
    checks++;
    if (mask !== {16'd0, b}) begin
      errors++;
      $display("FAIL %s add_sel mask: got %h expected %h", name, mask, {16'd0, b});
    end
  endtask

  task automatic do_ack();
    iAck = 1'b1;
    tick();
    iAck = 1'b0;
    checks++;
    if (oReady !== 1'b1 || oDone !== 1'b0 || prod !== 32'd0) begin
      errors++;
      $display("FAIL ack: oReady=%b oDone=%b prod=%h expected 1 0 0", oReady, oDone, prod);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
    checks++;
    if (oReady !== 1'b1 || oDone !== 1'b0 || Shift_Enable !== 1'b0 || oIter !== '0 ||
        a_sel !== 1'b0 || b_sel !== 1'b0 || prod_sel !== 1'b0 || add_sel !== 1'b0) begin
      errors++;
      $display("FAIL reset: rdy=%b done=%b se=%b iter=%0d a=%b b=%b p=%b add=%b", oReady,
               oDone, Shift_Enable, oIter, a_sel, b_sel, prod_sel, add_sel);
    end
  endtask

  task automatic test_basic();
    check_mult("3x5", 16'd3, 16'd5, -1);
    do_ack();
  endtask

  task automatic test_hold();
    logic [31:0] held;
    check_mult("ffffxffff", 16'hFFFF, 16'hFFFF, -1);
    held = prod;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (oDone !== 1'b1 || prod !== 32'hFFFE0001 || prod !== held) begin
        errors++;
        $display("FAIL hold cycle %0d: oDone=%b prod=%h expected 1 fffe0001", i, oDone, prod);
      end
    end
    do_ack();
  endtask

  task automatic test_zero_b();
    check_mult("123x0", 16'd123, 16'd0, -1);
    do_ack();
  endtask

  task automatic test_reset_mid_calc();
    int n;
    Data_A = 32'd11;
    Data_B = 32'd13;
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    n = 0;
    while (oIter != CNT_W'(10) && n < 50) begin
      tick();
      n++;
    end
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    checks++;
    if (oReady !== 1'b1 || oIter !== '0 || Shift_Enable !== 1'b0) begin
      errors++;
      $display("FAIL reset mid calc: oReady=%b oIter=%0d se=%b expected 1 0 0", oReady, oIter,
               Shift_Enable);
    end
    check_mult("7x9 after reset", 16'd7, 16'd9, -1);
    do_ack();
  endtask

  task automatic test_start_ignored();
    check_mult("start in calc", 16'd201, 16'd77, 2);
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    checks++;
    if (oDone !== 1'b1 || prod !== 32'd15477) begin
      errors++;
      $display("FAIL start in done: oDone=%b prod=%h expected 1 %h", oDone, prod, 32'd15477);
    end
    iStart = 1'b1;
    iAck = 1'b1;
    tick();
    iStart = 1'b0;
    iAck = 1'b0;
    checks++;
    if (oDone !== 1'b0 || oReady !== 1'b1) begin
      errors++;
      $display("FAIL start+ack: oDone=%b oReady=%b expected 0 1", oDone, oReady);
    end
    tick();
    checks++;
    if (oReady !== 1'b1 || Shift_Enable !== 1'b0) begin
      errors++;
      $display("FAIL no restart: oReady=%b se=%b expected 1 0", oReady, Shift_Enable);
    end
  endtask

  task automatic test_early_exit();
    check_mult("10x6", 16'd10, 16'd6, -1);
    do_ack();
  endtask

  task automatic test_random();
    logic [15:0] a, b;
    for (int i = 0; i < 12; i++) begin
      a = 16'($urandom);
      b = (i % 3 == 0) ? 16'($urandom_range(0, 63)) : 16'($urandom);
      check_mult("random", a, b, -1);
      for (int w = 0; w < int'($urandom_range(0, 3)); w++) tick();
      do_ack();
    end
  endtask

  initial begin
    tick();
    test_reset();
    test_basic();
    test_hold();
    test_zero_b();
    test_reset_mid_calc();
    test_start_ignored();
    test_early_exit();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
